// File: rtl/core_pkg.sv
// Shared definitions for the RV32I control path: function codes, FSM state
// encoding and trap causes.
package core_pkg;

   localparam int FC_W = 6;

   localparam logic [FC_W-1:0] FC_JAL  = 6'h15;
   localparam logic [FC_W-1:0] FC_JALR = 6'h16;
   localparam logic [FC_W-1:0] FC_BEQ  = 6'h17;
   localparam logic [FC_W-1:0] FC_BNE  = 6'h18;
   localparam logic [FC_W-1:0] FC_BLT  = 6'h19;
   localparam logic [FC_W-1:0] FC_BGE  = 6'h1A;
   localparam logic [FC_W-1:0] FC_BLTU = 6'h1B;
   localparam logic [FC_W-1:0] FC_BGEU = 6'h1C;
   localparam logic [FC_W-1:0] FC_LB   = 6'h1D;
   localparam logic [FC_W-1:0] FC_LH   = 6'h1E;
   localparam logic [FC_W-1:0] FC_LW   = 6'h1F;
   localparam logic [FC_W-1:0] FC_LBU  = 6'h20;
   localparam logic [FC_W-1:0] FC_LHU  = 6'h21;
   localparam logic [FC_W-1:0] FC_SB   = 6'h22;
   localparam logic [FC_W-1:0] FC_SH   = 6'h23;
   localparam logic [FC_W-1:0] FC_SW   = 6'h24;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_ILLEGAL = 2'd1,
      CAUSE_IMEM_TO = 2'd2,
      CAUSE_DMEM_TO = 2'd3
   } cause_t;

   function automatic logic is_branch(input logic [FC_W-1:0] fc);
      return (fc >= FC_BEQ) && (fc <= FC_BGEU);
   endfunction

endpackage

// File: rtl/seq_timeout.sv
// Wait-cycle counter shared by the fetch and data-memory handshakes; flags
// the last unacknowledged cycle allowed before the sequencer must trap.
module seq_timeout #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam bit EN = (LIMIT > 0);
   localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CW'(1);
      end
   end

   // Counter holds the number of earlier wait cycles, so matching LAST means
   // this cycle is the LIMIT-th one without an ack.
   assign expired = EN && (count == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH, DECODE, EXEC, optional MEM, WB,
// with handshake timeouts and a sticky TRAP state.
module core_sequencer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int FC_W        = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   output logic            imem_req,
   input  logic            imem_ack,
   output logic            ir_we,
   input  logic [FC_W-1:0] func_code,
   input  logic            illegal,
   input  logic            rd_en,
   input  logic            ld_en,
   input  logic            st_en,
   input  logic            branch_taken,
   output logic            exec_en,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   output logic            rf_we,
   output logic            pc_we,
   output logic            pc_sel,
   output logic [2:0]      state,
   output logic            trap,
   output logic [1:0]      trap_cause,
   output logic [31:0]     instret
);

   import core_pkg::*;

   state_t      state_q, state_d;
   cause_t      cause_q, cause_d;
   logic [31:0] instret_q;
   logic        to_clr, to_inc, to_expired;

   assign to_clr = (state_q != ST_FETCH) && (state_q != ST_MEM);
   assign to_inc = ((state_q == ST_FETCH) && !imem_ack) ||
                   ((state_q == ST_MEM)   && !dmem_ack);

   seq_timeout #(.LIMIT(MEM_TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (to_clr),
      .inc     (to_inc),
      .expired (to_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cause_q   <= CAUSE_NONE;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         if (state_q == ST_WB) begin
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      exec_en  = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            // An ack arriving on the final allowed cycle still completes.
            if (imem_ack) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end else if (to_expired) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_IMEM_TO;
            end
         end
         ST_DECODE: begin
            if (illegal) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            exec_en = 1'b1;
            state_d = (ld_en || st_en) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = st_en;
            if (dmem_ack) begin
               state_d = ST_WB;
            end else if (to_expired) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_DMEM_TO;
            end
         end
         ST_WB: begin
            rf_we   = rd_en;
            pc_we   = 1'b1;
            pc_sel  = (func_code == FC_JAL) || (func_code == FC_JALR) ||
                      (is_branch(func_code) && branch_taken);
            state_d = run ? ST_FETCH : ST_IDLE;
         end
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign state      = state_q;
   assign trap       = (state_q == ST_TRAP);
   assign trap_cause = cause_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Cycle-level bench for core_sequencer: each instruction is expanded into an
// expected per-cycle trace from its class and wait counts, then replayed.
module tb_core_sequencer;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst, run, imem_ack, dmem_ack, illegal, rd_en, ld_en, st_en, branch_taken;
   logic [5:0]  func_code;
   logic        imem_req, ir_we, exec_en, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap;
   logic [2:0]  state;
   logic [1:0]  trap_cause;
   logic [31:0] instret;

   core_sequencer #(.MEM_TIMEOUT(TO), .FC_W(6)) dut (
      .clk(clk), .rst(rst), .run(run),
      .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
      .func_code(func_code), .illegal(illegal), .rd_en(rd_en),
      .ld_en(ld_en), .st_en(st_en), .branch_taken(branch_taken),
      .exec_en(exec_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_ack(dmem_ack), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
      .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [13:0] exp_q[$];
   logic [3:0]  stim_q[$];
   logic [31:0] model_instret;
   bit          in_idle, trapped;
   logic [5:0]  cur_fc;
   logic        cur_ill, cur_rd, cur_ld, cur_st, cur_bt;

   logic [13:0] obs;
   assign obs = {state, imem_req, ir_we, exec_en, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
                 trap, trap_cause};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // strobes order: imem_req ir_we exec_en dmem_req dmem_we rf_we pc_we pc_sel
   function automatic logic [13:0] mk(input logic [2:0] st, input logic [7:0] s,
                                      input logic tr, input logic [1:0] c);
      return {st, s, tr, c};
   endfunction

   // stimulus bits: {is_wb, run, imem_ack, dmem_ack}
   task automatic push(input logic [3:0] s, input logic [13:0] e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic add_trap(input logic [1:0] c, input int n);
      logic [2:0] r;
      for (int k = 0; k < n; k++) begin
         r = 3'($urandom);
         push({1'b0, r}, mk(3'd7, 8'h00, 1'b1, c));
      end
      trapped = 1'b1;
   endtask

   // kind: 0 alu, 1 jump, 2 branch, 3 load, 4 store, 5 illegal
   task automatic gen(input int kind, input int wi, input int wd, input bit stop, input int ntrap);
      logic [1:0] r;
      logic       a, psel;
      cur_ill = (kind == 5);
      cur_ld  = (kind == 3);
      cur_st  = (kind == 4);
      cur_rd  = (kind == 0) || (kind == 1) || (kind == 3);
      cur_bt  = 1'($urandom_range(0, 1));
      case (kind)
         0:       cur_fc = 6'($urandom_range(0, 'h14));
         1:       cur_fc = 6'($urandom_range('h15, 'h16));
         2:       cur_fc = 6'($urandom_range('h17, 'h1C));
         3:       cur_fc = 6'($urandom_range('h1D, 'h21));
         4:       cur_fc = 6'($urandom_range('h22, 'h24));
         default: cur_fc = 6'($urandom_range(0, 63));
      endcase
      trapped = 1'b0;
      if (in_idle) begin
         r = 2'($urandom);
         push({2'b01, r}, mk(3'd0, 8'h00, 1'b0, 2'd0));
         in_idle = 1'b0;
      end
      for (int k = 0; k < TO; k++) begin
         a = (k == wi);
         r = 2'($urandom);
         push({2'b01, a, r[0]}, mk(3'd1, {1'b1, a, 6'b0}, 1'b0, 2'd0));
         if (a) break;
      end
      if (wi >= TO) begin
         add_trap(2'd2, ntrap);
         return;
      end
      r = 2'($urandom);
      push({2'b01, r}, mk(3'd2, 8'h00, 1'b0, 2'd0));
      if (cur_ill) begin
         add_trap(2'd1, ntrap);
         return;
      end
      r = 2'($urandom);
      push({1'b0, !stop, r}, mk(3'd3, 8'b0010_0000, 1'b0, 2'd0));
      if (cur_ld || cur_st) begin
         for (int k = 0; k < TO; k++) begin
            a = (k == wd);
            r = 2'($urandom);
            push({1'b0, !stop, r[0], a}, mk(3'd4, {3'b000, 1'b1, cur_st, 3'b000}, 1'b0, 2'd0));
            if (a) break;
         end
         if (wd >= TO) begin
            add_trap(2'd3, ntrap);
            return;
         end
      end
      psel = (kind == 1) || ((kind == 2) && cur_bt);
      r = 2'($urandom);
      push({1'b1, !stop, r}, mk(3'd5, {5'b0, cur_rd, 1'b1, psel}, 1'b0, 2'd0));
      if (stop) begin
         for (int k = 0; k < 2; k++) begin
            r = 2'($urandom);
            push({2'b00, r}, mk(3'd0, 8'h00, 1'b0, 2'd0));
         end
         in_idle = 1'b1;
      end
   endtask

   task automatic play(input int n);
      logic [3:0]  s;
      logic [13:0] e;
      int          m;
      m = n;
      while (stim_q.size() > 0 && m > 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         @(negedge clk);
         run          = s[2];
         imem_ack     = s[1];
         dmem_ack     = s[0];
         func_code    = cur_fc;
         illegal      = cur_ill;
         rd_en        = cur_rd;
         ld_en        = cur_ld;
         st_en        = cur_st;
         branch_taken = cur_bt;
         #1;
         check("outputs", {18'd0, obs}, {18'd0, e});
         check("instret", instret, model_instret);
         if (s[3]) model_instret = model_instret + 32'd1;
         m--;
      end
      stim_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      run      = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      model_instret = 32'd0;
      check("rst_outputs", {18'd0, obs}, 32'd0);
      check("rst_instret", instret, 32'd0);
      in_idle = 1'b1;
   endtask

   initial begin
      int k, wi, wd;
      rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      illegal = 1'b0; rd_en = 1'b0; ld_en = 1'b0; st_en = 1'b0;
      branch_taken = 1'b0; func_code = 6'd0;
      model_instret = 32'd0;
      in_idle = 1'b1;
      trapped = 1'b0;
      do_reset();

      gen(0, 0, 0, 0, 0); play(1000);
      gen(3, 0, 3, 0, 0); play(1000);
      gen(4, 0, 0, 0, 0); play(1000);
      gen(2, 0, 0, 0, 0); play(1000);
      gen(2, 1, 1, 0, 0); play(1000);
      // Reset while a load waits on dmem_ack.
      gen(3, 0, 9, 0, 0); play(4);
      do_reset();
      gen(5, 0, 0, 0, 20); play(1000);
      do_reset();
      gen(0, 4, 0, 0, 5);  play(1000);
      do_reset();
      gen(0, 3, 0, 0, 0);  play(1000);
      gen(3, 0, 4, 0, 5);  play(1000);
      do_reset();
      gen(4, 1, 3, 0, 0);  play(1000);
      gen(0, 0, 0, 1, 0);  play(1000);

      for (int i = 0; i < 200; i++) begin
         k  = $urandom_range(0, 9);
         wi = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
         wd = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
         case (k)
            0, 1:    gen(0, wi, wd, ($urandom_range(0, 5) == 0), 4);
            2:       gen(1, wi, wd, ($urandom_range(0, 5) == 0), 4);
            3, 4:    gen(2, wi, wd, ($urandom_range(0, 5) == 0), 4);
            5, 6:    gen(3, wi, wd, ($urandom_range(0, 5) == 0), 4);
            7, 8:    gen(4, wi, wd, ($urandom_range(0, 5) == 0), 4);
            default: gen(5, wi, wd, 1'b0, 4);
         endcase
         play(1000);
         if (trapped) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
